// File: rtl/rr_burst_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter_pkg
//   Shared definitions for the round-robin burst arbiter: FSM state encoding
//   and the constant clog2 helper used to size channel-index and burst-count
//   fields.
// -----------------------------------------------------------------------------
package rr_burst_arbiter_pkg;

  // IDLE: searching for the next channel. BURST: a channel owns the output.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Ceiling log2, usable in parameter/port declarations. clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter_if
//   Source-side and sink-side handshake bundle of the arbiter.
//     req        : per-channel FIFO not-empty (first-word-fall-through)
//     hold       : per-channel "packet not complete, keep the grant"
//     data_in    : channel c on bits [c*DATA_WIDTH +: DATA_WIDTH]
//     read_grant : one-hot-or-zero pop strobe back to the sources
//     out_valid  : out_data/out_ch hold a word
//     out_data   : merged word
//     out_ch     : source index of out_data
//     out_ready  : downstream accepts out_data this cycle
//   Modports: master = arbiter side, slave = sources + sink side.
// -----------------------------------------------------------------------------
interface rr_burst_arbiter_if #(
  parameter int N_CH       = 10,
  parameter int DATA_WIDTH = 32
);
  import rr_burst_arbiter_pkg::*;

  localparam int CW = clog2(N_CH);

  logic [N_CH-1:0]            req;
  logic [N_CH-1:0]            hold;
  logic [N_CH*DATA_WIDTH-1:0] data_in;
  logic [N_CH-1:0]            read_grant;
  logic                       out_valid;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [CW-1:0]              out_ch;
  logic                       out_ready;

  modport master (
    input  req, hold, data_in, out_ready,
    output read_grant, out_valid, out_data, out_ch
  );

  modport slave (
    output req, hold, data_in, out_ready,
    input  read_grant, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Rotating priority search: returns the first set bit of `eligible`
//   looking upward from (last + 1) mod N_CH, wrapping around. `last` itself
//   is examined last, so a lone requester keeps winning.
//   Ports:
//     eligible : candidate mask
//     last     : channel most recently granted
//     found    : at least one bit of eligible is set
//     index    : winning channel (0 when found = 0)
// -----------------------------------------------------------------------------
module rr_pick
  import rr_burst_arbiter_pkg::*;
#(
  parameter int  N_CH = 10,
  localparam int CW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CW-1:0]   last,
  output logic            found,
  output logic [CW-1:0]   index
);

  // (base + off) mod N_CH for off in 1..N_CH; one subtraction is enough.
  function automatic int wrap_add(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= N_CH) ? s - N_CH : s;
  endfunction

  logic [CW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path
    // that assigns nothing would infer a latch.
    found = 1'b0;
    index = '0;
    cand  = '0;
    // Walk from the farthest offset to the nearest so the nearest eligible
    // channel is the last assignment and therefore wins.
    for (int off = N_CH; off >= 1; off--) begin
      cand = CW'(wrap_add(last, off));
      if (eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   Merges N_CH first-word-fall-through sources onto one output stream.
//   Channels are served round-robin; a winner keeps the grant for up to
//   burst_len words (0 behaves as 1), longer while it asserts hold, and the
//   granted word is registered onto out_data with one cycle of latency at
//   full throughput.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clean deassertion
//                  is provided by the reset synchroniser at instantiation)
//     ch_en      : per-channel enable mask
//     burst_len  : words per grant, sampled when a grant starts
//     busy       : FSM is in BURST
//     bus        : source/sink handshake (rr_burst_arbiter_if.master)
// -----------------------------------------------------------------------------
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int  N_CH       = 10,
  parameter int  DATA_WIDTH = 32,
  parameter int  BURST_MAX  = 16,
  localparam int BW         = clog2(BURST_MAX + 1),
  localparam int CW         = clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     ch_en,
  input  logic [BW-1:0]       burst_len,
  output logic                busy,
  rr_burst_arbiter_if.master  bus
);

  localparam logic [CW-1:0] LAST_RST = CW'(N_CH - 1);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cur_q;
  logic [CW-1:0]         last_q;
  logic [BW-1:0]         cnt_q;
  logic [BW-1:0]         len_q;
  logic [BW-1:0]         cnt_next;
  logic [BW-1:0]         eff_len;

  logic [N_CH-1:0]       eligible;
  logic                  space;
  logic                  pick_found;
  logic [CW-1:0]         pick_idx;

  logic                  start;
  logic                  grant_any;
  logic [CW-1:0]         grant_idx;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CW-1:0]         out_ch_q;

  // The output register can take a word if it is empty or being drained.
  assign space    = !out_valid_q || bus.out_ready;
  assign eligible = bus.req & ch_en;
  assign eff_len  = (burst_len == '0) ? BW'(1) : burst_len;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------- output comb
  // Grant decision, pop strobe and busy flag.
  always_comb begin
    start     = 1'b0;
    grant_any = 1'b0;
    grant_idx = cur_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found && space) begin
          start     = 1'b1;
          grant_any = 1'b1;
          grant_idx = pick_idx;
        end
      end
      ST_BURST: begin
        // A disabled owner gets nothing this cycle; the FSM releases below.
        if (ch_en[cur_q] && bus.req[cur_q] && space) grant_any = 1'b1;
      end
      default: ;
    endcase
    // Reset gates the pop strobe combinationally, ahead of the flops.
    if (!rst_n) begin
      start     = 1'b0;
      grant_any = 1'b0;
    end
    bus.read_grant = grant_any ? (N_CH'(1) << grant_idx) : '0;
    busy           = (state_q == ST_BURST);
  end

  // Word count including this cycle's grant, saturating at BURST_MAX.
  always_comb begin
    cnt_next = cnt_q;
    if (start)                                       cnt_next = BW'(1);
    else if (grant_any && (cnt_q < BW'(BURST_MAX)))  cnt_next = cnt_q + BW'(1);
  end

  // ----------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A one-word grant without hold is already complete: stay in IDLE
        // so the next channel can be picked on the very next cycle.
        if (start && (bus.hold[pick_idx] || (eff_len > BW'(1))))
          state_d = ST_BURST;
      end
      ST_BURST: begin
        if (!ch_en[cur_q])
          state_d = ST_IDLE;
        else if (!bus.hold[cur_q] && ((cnt_next >= len_q) || !bus.req[cur_q]))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------- burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      last_q <= LAST_RST;   // channel 0 is searched first out of reset
      cnt_q  <= '0;
      len_q  <= '0;
    end else begin
      cnt_q <= cnt_next;
      if (start) begin
        cur_q  <= pick_idx;
        last_q <= pick_idx;
        len_q  <= eff_len;  // burst length is frozen for this grant
      end
    end
  end

  // ------------------------------------------------------------ output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so out_data reads a defined 0
      // after reset rather than whatever the flops powered up with.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (grant_any) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.data_in[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      out_ch_q    <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_burst_arbiter
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the arbitration rules kept in this file. Each source
//   is a counter-backed FIFO whose words encode {channel, sequence number}.
// -----------------------------------------------------------------------------
module tb_rr_burst_arbiter;
  import rr_burst_arbiter_pkg::*;

  localparam int N_CH      = 10;
  localparam int DW        = 32;
  localparam int BURST_MAX = 16;
  localparam int BW        = clog2(BURST_MAX + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] ch_en;
  logic [BW-1:0]   burst_len;
  logic            busy;

  rr_burst_arbiter_if #(.N_CH(N_CH), .DATA_WIDTH(DW)) bus ();

  rr_burst_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .burst_len (burst_len),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Sources
  int              fifo_cnt [N_CH];
  int              seq      [N_CH];
  logic [N_CH-1:0] req_v;
  logic [N_CH-1:0] hold_v;
  bit              ready_v;

  // Reference model state
  bit              m_busy;
  int              m_cur, m_last, m_cnt, m_len;
  bit              m_ov;
  logic [DW-1:0]   m_od;
  int              m_och;

  // Observation log
  int              acc_ch[$];
  logic [DW-1:0]   acc_data[$];
  logic [N_CH-1:0] last_rg;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_rot  [10] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2};
  int exp_hold [9]  = '{3, 3, 3, 3, 3, 3, 3, 1, 1};
  int exp_alt  [6]  = '{0, 9, 0, 9, 0, 9};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int c, input int s);
    return (DW'(c) << 24) | (DW'(s) & 32'h00FF_FFFF);
  endfunction

  function automatic int rr_search(input logic [N_CH-1:0] elig, input int last);
    for (int k = 1; k <= N_CH; k++)
      if (elig[(last + k) % N_CH]) return (last + k) % N_CH;
    return -1;
  endfunction

  task automatic drive_sources();
    logic [N_CH*DW-1:0] d;
    d = '0;
    for (int c = 0; c < N_CH; c++) begin
      req_v[c]         = (fifo_cnt[c] > 0);
      d[c*DW +: DW]    = word_of(c, seq[c]);
    end
    bus.req       = req_v;
    bus.hold      = hold_v;
    bus.data_in   = d;
    bus.out_ready = ready_v;
  endtask

  task automatic clear_sources();
    for (int c = 0; c < N_CH; c++) fifo_cnt[c] = 0;
    hold_v    = '0;
    ch_en     = '1;
    ready_v   = 1'b1;
    burst_len = BW'(4);
    drive_sources();
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_cur = 0; m_last = N_CH - 1; m_cnt = 0; m_len = 1;
    m_ov = 1'b0; m_od = '0; m_och = 0;
  endtask

  // One clock of the arbitration rules; g = granted channel or -1.
  task automatic model_step(output int g);
    bit space;
    int eff;
    int p;
    space = !m_ov || ready_v;
    eff   = (burst_len == 0) ? 1 : int'(burst_len);
    g     = -1;
    if (!m_busy) begin
      p = rr_search(req_v & ch_en, m_last);
      if (p >= 0 && space) begin
        g = p; m_cur = p; m_last = p; m_cnt = 1; m_len = eff;
        m_busy = hold_v[p] || (m_cnt < m_len);
      end
    end else if (!ch_en[m_cur]) begin
      m_busy = 1'b0;
    end else begin
      if (req_v[m_cur] && space) begin
        g = m_cur;
        if (m_cnt < BURST_MAX) m_cnt++;
      end
      if (!hold_v[m_cur] && (m_cnt >= m_len || !req_v[m_cur])) m_busy = 1'b0;
    end
    if (g >= 0) begin
      m_ov = 1'b1; m_od = word_of(g, seq[g]); m_och = g;
    end else if (ready_v) begin
      m_ov = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; samples the DUT 3 time units later.
  task automatic run_cycle();
    int g;
    drive_sources();
    #3;
    check("out_valid", bus.out_valid, m_ov);
    check("out_data",  bus.out_data,  m_od);
    check("out_ch",    bus.out_ch,    m_och);
    check("busy",      busy,          m_busy);
    model_step(g);
    check("read_grant", bus.read_grant, (g >= 0) ? (64'(1) << g) : 64'(0));
    last_rg = bus.read_grant;
    if (bus.out_valid && ready_v) begin
      acc_ch.push_back(int'(bus.out_ch));
      acc_data.push_back(bus.out_data);
    end
    @(posedge clk); #1;
    if (g >= 0) begin
      fifo_cnt[g]--;
      seq[g]++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_read_grant", bus.read_grant, 0);
    check("rst_out_valid",  bus.out_valid,  0);
    check("rst_busy",       busy,           0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_data",   bus.out_data,   0);
    check("rst_out_ch",     bus.out_ch,     0);
    check("rst_grant_held", bus.read_grant, 0);
    rst_n = 1'b1;
    model_reset();
    acc_ch.delete();
    acc_data.delete();
  endtask

  initial begin
    int base;
    int n6;
    for (int c = 0; c < N_CH; c++) seq[c] = 0;
    rst_n = 1'b0;
    clear_sources();

    // Reset with every channel requesting: channel 0 must win first.
    for (int c = 0; c < N_CH; c++) fifo_cnt[c] = 5;
    drive_sources();
    apply_reset();
    run_cycle();
    check("first_grant", last_rg, 64'(1));
    run_cycle();
    check("first_out_valid", bus.out_valid, 1);
    check("first_out_ch",    bus.out_ch,    0);
    repeat (6) run_cycle();

    // Burst rotation between channels 2 and 5, no idle cycles.
    clear_sources();
    apply_reset();
    fifo_cnt[2] = 100; fifo_cnt[5] = 100; burst_len = BW'(4);
    repeat (12) run_cycle();
    check("rot_count", acc_ch.size(), 11);
    for (int i = 0; i < 10; i++) check($sformatf("rot_seq[%0d]", i), acc_ch[i], exp_rot[i]);

    // Hold keeps channel 3 for 7 words although burst_len is 2.
    clear_sources();
    apply_reset();
    fifo_cnt[3] = 20; burst_len = BW'(2);
    base = seq[3];
    for (int i = 0; i < 12; i++) begin
      hold_v[3] = ((seq[3] - base) < 6);
      run_cycle();
      if (i == 0) fifo_cnt[1] = 20;
    end
    for (int i = 0; i < 9; i++) check($sformatf("hold_seq[%0d]", i), acc_ch[i], exp_hold[i]);

    // Backpressure mid-burst.
    clear_sources();
    apply_reset();
    fifo_cnt[6] = 10; burst_len = BW'(8);
    base = seq[6];
    repeat (3) run_cycle();
    ready_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("bp_no_grant", last_rg, 0);
      check("bp_stable",   bus.out_data, word_of(6, base + 2));
    end
    ready_v = 1'b1;
    repeat (15) run_cycle();
    n6 = 0;
    foreach (acc_ch[i]) begin
      if (acc_ch[i] == 6) begin
        check($sformatf("bp_word[%0d]", n6), acc_data[i], word_of(6, base + n6));
        n6++;
      end
    end
    check("bp_word_count", n6, 10);

    // Disable channel 4 while it holds the grant.
    clear_sources();
    apply_reset();
    fifo_cnt[4] = 20; fifo_cnt[7] = 20; hold_v[4] = 1'b1; burst_len = BW'(4);
    repeat (3) run_cycle();
    ch_en[4] = 1'b0;
    run_cycle();
    check("dis_no_pop", last_rg, 0);
    run_cycle();
    check("dis_next", last_rg, 64'(1) << 7);
    ch_en[4] = 1'b1; hold_v[4] = 1'b0;
    repeat (4) run_cycle();

    // burst_len = 0 acts as 1: strict alternation with 9 -> 0 wrap.
    clear_sources();
    apply_reset();
    fifo_cnt[0] = 20; fifo_cnt[9] = 20; burst_len = '0;
    repeat (8) run_cycle();
    check("alt_count", acc_ch.size(), 7);
    for (int i = 0; i < 6; i++) check($sformatf("alt_seq[%0d]", i), acc_ch[i], exp_alt[i]);

    // Randomized traffic, including one reset in the middle of the run.
    clear_sources();
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_CH; c++)
        if (fifo_cnt[c] == 0 && $urandom_range(0, 7) == 0) fifo_cnt[c] = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) hold_v = N_CH'($urandom) & N_CH'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        int ch;
        ch = $urandom_range(0, N_CH - 1);
        ch_en[ch] = ~ch_en[ch];
      end
      if ($urandom_range(0, 19) == 0) burst_len = BW'($urandom_range(0, BURST_MAX));
      ready_v = ($urandom_range(0, 3) != 0);
      if (cyc == 1500) begin
        drive_sources();
        apply_reset();
      end
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
